// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared definitions for the instruction-memory loader.
//                It holds the loader FSM state encoding and the number of
//                bytes that make up one instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states, with fixed 2-bit encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One instruction word is assembled from this many bytes
    localparam int unsigned c_bytes_per_word = 4;
    localparam int unsigned c_byte_cnt_w     = $clog2(c_bytes_per_word);

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : 8-to-32-bit little-endian shift register. Each pushed byte
//                enters at the top and the word shifts right, so the first
//                byte of a word ends up in [7:0] and the fourth in [31:24].
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                i_clear - drop any partial word (priority over i_push)
//                i_push  - shift in i_byte
//                i_byte  - incoming byte
//                o_word  - assembled word
//                o_count - bytes held in the current word (wraps at 4)
//                o_full  - a complete word is held
//  Revision    : 1.0 - initial release
// ============================================================================
module word_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic [7:0]              i_byte,
    output logic [31:0]             o_word,
    output logic [c_byte_cnt_w-1:0] o_count,
    output logic                    o_full
);

    localparam logic [c_byte_cnt_w-1:0] c_last = c_byte_cnt_w'(c_bytes_per_word - 1);

    logic [31:0]             r_shift;
    logic [c_byte_cnt_w-1:0] r_count;
    logic                    r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_clear) begin
            // Stale data bits are left in place; four fresh pushes overwrite them
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_push) begin
            r_shift <= {i_byte, r_shift[31:8]};
            r_count <= r_count + 1'b1;
            r_full  <= (r_count == c_last);
        end
    end

    assign o_word  = r_shift;
    assign o_count = r_count;
    assign o_full  = r_full;

endmodule : word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program image, received as a byte stream, into
//                instruction memory. Start with a legal Len opens a session;
//                bytes are packed little-endian into 32-bit words, and each
//                word is written at the next word address. The CPU fetch
//                stage is held while a session is active.
//  Ports       : Clk, Reset (async, active-low)
//                Start, Len        - session request and word count
//                Abort             - cancel the active session
//                Byte_Data/Valid/Ready - byte stream handshake
//                Mem_WrEn/Addr/Din - instruction-memory write port
//                Cpu_Hold, Busy    - session in progress
//                Done, Error       - one-cycle completion / illegal-Len pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Len,
    input  logic                  Abort,
    input  logic [7:0]            Byte_Data,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Mem_WrEn,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [31:0]           Mem_Din,
    output logic                  Cpu_Hold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam logic [ADDR_WIDTH:0]     c_max_len   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]     c_one       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [c_byte_cnt_w-1:0] c_last_byte = c_byte_cnt_w'(c_bytes_per_word - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH:0]     r_len;
    logic [ADDR_WIDTH-1:0]   r_word_idx;
    logic                    r_error;

    logic                    w_len_ok;
    logic                    w_start_ok;
    logic                    w_accept;
    logic                    w_last_byte;
    logic [ADDR_WIDTH:0]     w_idx_next;
    logic                    w_more_words;
    logic                    w_busy;

    logic                    w_pk_clear;
    logic [31:0]             w_pk_word;
    logic [c_byte_cnt_w-1:0] w_pk_count;
    logic                    w_pk_full;

    assign w_len_ok     = (Len != '0) && (Len <= c_max_len);
    assign w_start_ok   = (r_state == ST_IDLE) && Start && w_len_ok;
    assign w_accept     = Byte_Valid && (r_state == ST_LOAD);
    assign w_last_byte  = w_accept && (w_pk_count == c_last_byte);
    // Index arithmetic is one bit wider so Len = 2^ADDR_WIDTH compares correctly
    assign w_idx_next   = {1'b0, r_word_idx} + c_one;
    assign w_more_words = (w_idx_next < r_len);

    // The packer only holds state while loading; leaving LOAD (to WRITE,
    // on abort, or in idle) drops any partial word.
    assign w_pk_clear = (r_state != ST_LOAD) || Abort;

    word_packer u_word_packer (
        .clk     (Clk),
        .rst_n   (Reset),
        .i_clear (w_pk_clear),
        .i_push  (w_accept),
        .i_byte  (Byte_Data),
        .o_word  (w_pk_word),
        .o_count (w_pk_count),
        .o_full  (w_pk_full)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_error <= (r_state == ST_IDLE) && Start && !w_len_ok;
            if (w_start_ok) begin
                r_len      <= Len;
                r_word_idx <= '0;
            end else if ((r_state == ST_WRITE) && !Abort && w_more_words) begin
                // The last index is never incremented, so Mem_Addr cannot wrap
                r_word_idx <= w_idx_next[ADDR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        Byte_Ready   = 1'b0;
        Mem_WrEn     = 1'b0;
        Done         = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_start_ok)
                    w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                Byte_Ready = 1'b1;
                // Abort beats a simultaneous fourth-byte accept
                if (Abort)
                    w_next_state = ST_IDLE;
                else if (w_last_byte)
                    w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                Mem_WrEn = w_pk_full && !Abort;
                if (Abort)
                    w_next_state = ST_IDLE;
                else if (w_more_words)
                    w_next_state = ST_LOAD;
                else
                    w_next_state = ST_DONE;
            end
            ST_DONE: begin
                Done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign Busy     = w_busy;
    assign Cpu_Hold = w_busy;
    assign Error    = r_error;
    assign Mem_Addr = r_word_idx;
    // Mem_Din is only meaningful while Mem_WrEn is high
    assign Mem_Din  = w_pk_word;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Each session's expected
//                memory writes are computed from the byte list and Len
//                (little-endian packing, one word per four bytes, addresses
//                counting from zero) and compared by a write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int AW = 10;

    logic          Clk        = 1'b0;
    logic          Reset      = 1'b0;
    logic          Start      = 1'b0;
    logic [AW:0]   Len        = '0;
    logic          Abort      = 1'b0;
    logic [7:0]    Byte_Data  = '0;
    logic          Byte_Valid = 1'b0;
    logic          Byte_Ready;
    logic          Mem_WrEn;
    logic [AW-1:0] Mem_Addr;
    logic [31:0]   Mem_Din;
    logic          Cpu_Hold;
    logic          Busy;
    logic          Done;
    logic          Error;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Len        (Len),
        .Abort      (Abort),
        .Byte_Data  (Byte_Data),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Mem_WrEn   (Mem_WrEn),
        .Mem_Addr   (Mem_Addr),
        .Mem_Din    (Mem_Din),
        .Cpu_Hold   (Cpu_Hold),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    int         gap_q[$];
    int         n_vec     = 0;
    int         n_bad     = 0;
    int         done_seen = 0;
    int         err_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Write monitor: every strobe must match the next expected write
    always @(negedge Clk) begin
        if (Reset) begin
            if (Done)  done_seen++;
            if (Error) err_seen++;
            if (Mem_WrEn) begin
                chk("wr_hold", 32'(Cpu_Hold), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("wr_unexp", 32'(Mem_WrEn), 32'd0);
                end else begin
                    chk("wr_addr", 32'(Mem_Addr), 32'(exp_q[0].a));
                    chk("wr_data", Mem_Din, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic fill_random(input int n, input int maxgap);
        byte_q.delete();
        gap_q.delete();
        for (int i = 0; i < n; i++) begin
            byte_q.push_back(8'($urandom));
            if (maxgap > 0 && $urandom_range(0, 3) == 0)
                gap_q.push_back(int'($urandom_range(1, maxgap)));
            else
                gap_q.push_back(0);
        end
    endtask

    task automatic push_words(input int nw);
        for (int i = 0; i < nw; i++)
            exp_q.push_back('{a: AW'(i),
                              d: {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]}});
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, input bit abort_with);
        bit acc;
        Byte_Valid = 1'b0;
        repeat (gap) tick();
        Byte_Valid = 1'b1;
        Byte_Data  = b;
        if (abort_with) begin
            chk("rdy_pre", 32'(Byte_Ready), 32'd1);
            Abort = 1'b1;
        end
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = Byte_Ready;
            if (noise && !abort_with) begin
                Start = ($urandom_range(0, 3) == 0);
                Len   = (AW+1)'($urandom);
            end
            tick();
        end
        Start      = 1'b0;
        Abort      = 1'b0;
        Byte_Valid = 1'b0;
        chk("byte_acc", 32'(acc), 32'd1);
    endtask

    // mode 0: complete; 1: Abort the cycle after the k-th byte;
    // 2: Abort together with the k-th byte (k a multiple of 4)
    task automatic run_session(input int len, input int mode, input int k, input bit noise);
        int nbytes, nw, d0, e0;
        nbytes = (mode == 0) ? len * 4 : k;
        nw     = (mode == 0) ? len : ((k % 4 == 0) ? k / 4 - 1 : k / 4);
        push_words(nw);
        d0 = done_seen;
        e0 = err_seen;
        Start = 1'b1;
        Len   = (AW+1)'(len);
        tick();
        Start = 1'b0;
        chk("busy_go", 32'(Busy), 32'd1);
        chk("hold_go", 32'(Cpu_Hold), 32'd1);
        chk("rdy_go", 32'(Byte_Ready), 32'd1);
        for (int i = 0; i < nbytes; i++)
            send_byte(byte_q[i], gap_q[i], noise, (mode == 2) && (i == nbytes - 1));
        if (mode == 0) begin
            tick();
            chk("done_pulse", 32'(Done), 32'd1);
            chk("busy_done", 32'(Busy), 32'd1);
            tick();
            chk("busy_end", 32'(Busy), 32'd0);
            chk("addr_end", 32'(Mem_Addr), 32'(len - 1));
        end else if (mode == 1) begin
            Abort = 1'b1;
            tick();
            Abort = 1'b0;
            chk("busy_abort", 32'(Busy), 32'd0);
        end else begin
            chk("busy_abort", 32'(Busy), 32'd0);
            chk("wr_abort", 32'(Mem_WrEn), 32'd0);
        end
        repeat (3) tick();
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        chk("done_cnt", 32'(done_seen - d0), 32'(mode == 0));
        chk("err_cnt", 32'(err_seen - e0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        // Reset state
        #3;
        chk("rst_ready", 32'(Byte_Ready), 32'd0);
        chk("rst_wren",  32'(Mem_WrEn), 32'd0);
        chk("rst_addr",  32'(Mem_Addr), 32'd0);
        chk("rst_din",   Mem_Din, 32'd0);
        chk("rst_hold",  32'(Cpu_Hold), 32'd0);
        chk("rst_busy",  32'(Busy), 32'd0);
        chk("rst_done",  32'(Done), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        repeat (2) tick();
        Reset = 1'b1;
        tick();

        // Two-word program
        byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h50, 8'h00};
        gap_q  = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_session(2, 0, 0, 1'b0);

        // Illegal lengths
        e0 = err_seen;
        Start = 1'b1; Len = '0;
        tick();
        Start = 1'b0;
        chk("busy_len0", 32'(Busy), 32'd0);
        tick();
        Start = 1'b1; Len = (AW+1)'(1025);
        tick();
        Start = 1'b0;
        chk("busy_len1025", 32'(Busy), 32'd0);
        repeat (2) tick();
        chk("err_pulses", 32'(err_seen - e0), 32'd2);
        chk("busy_err", 32'(Busy), 32'd0);

        // Byte_Valid pattern 1,0,0,1,1,0,1
        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        gap_q  = '{0, 2, 0, 1};
        run_session(1, 0, 0, 1'b0);

        // Abort after six bytes, then a fresh one-word session
        fill_random(12, 2);
        run_session(3, 1, 6, 1'b0);
        fill_random(4, 2);
        run_session(1, 0, 0, 1'b0);

        // Reset during the write of word 5 of an 8-word session
        fill_random(32, 1);
        push_words(5);
        Start = 1'b1; Len = (AW+1)'(8);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 24; i++)
            send_byte(byte_q[i], gap_q[i], 1'b0, 1'b0);
        chk("wr5_pre", 32'(Mem_WrEn), 32'd1);
        chk("wr5_addr", 32'(Mem_Addr), 32'd5);
        #2 Reset = 1'b0;
        #1;
        chk("arst_wren", 32'(Mem_WrEn), 32'd0);
        chk("arst_hold", 32'(Cpu_Hold), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_addr", 32'(Mem_Addr), 32'd0);
        chk("arst_din", Mem_Din, 32'd0);
        tick();
        tick();
        Reset = 1'b1;
        chk("q_pre_rst", 32'(exp_q.size()), 32'd0);
        Byte_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Byte_Data = 8'($urandom);
            tick();
        end
        chk("rdy_after_rst", 32'(Byte_Ready), 32'd0);
        Byte_Valid = 1'b0;
        tick();
        chk("busy_after_rst", 32'(Busy), 32'd0);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            int len, mode, k;
            len  = int'($urandom_range(1, 12));
            mode = int'($urandom_range(0, 2));
            if (mode == 1)
                k = int'($urandom_range(1, len * 4));
            else if (mode == 2)
                k = 4 * int'($urandom_range(1, len));
            else
                k = 0;
            fill_random(len * 4, 3);
            run_session(len, mode, k, 1'b1);
        end

        // Full memory load with an incrementing pattern
        fill_random(4096, 1);
        for (int i = 0; i < 4096; i++)
            byte_q[i] = 8'(i);
        run_session(1024, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
